// File: rtl/kf_pit_pkg.sv
// Shared encodings for the wide PIT counter channel: operating modes,
// read/write access codes from the control word, and status byte layout.
package kf_pit_pkg;

   // Decoded operating mode; MODE_RSVD covers the unsupported mode codes.
   typedef enum logic [1:0] {
      MODE0     = 2'd0,
      MODE2     = 2'd1,
      MODE3     = 2'd2,
      MODE_RSVD = 2'd3
   } mode_e;

   // Control word bits [5:4].
   typedef enum logic [1:0] {
      RW_LATCH  = 2'b00,
      RW_LSB    = 2'b01,
      RW_STATUS = 2'b10,
      RW_FULL   = 2'b11
   } rw_e;

   // Status byte bit positions.
   localparam int unsigned ST_OUT     = 7;
   localparam int unsigned ST_NULL    = 6;
   localparam int unsigned ST_RW_HI   = 5;
   localparam int unsigned ST_RW_LO   = 4;
   localparam int unsigned ST_MODE_HI = 3;
   localparam int unsigned ST_MODE_LO = 1;
   localparam int unsigned ST_BIT0    = 0;

   // Map the raw 3-bit mode field onto the supported modes.
   function automatic mode_e decode_mode(input logic [2:0] m);
      if (m == 3'b000) begin
         return MODE0;
      end else if (m[1:0] == 2'b10) begin
         return MODE2;
      end else if (m[1:0] == 2'b11) begin
         return MODE3;
      end else begin
         return MODE_RSVD;
      end
   endfunction

   // Assemble the status byte from its fields.
   function automatic logic [7:0] status_byte(input logic       out_bit,
                                              input logic       null_bit,
                                              input rw_e        rw,
                                              input logic [2:0] mode_raw,
                                              input logic       bit0);
      logic [7:0] s;
      s                        = 8'h00;
      s[ST_OUT]                = out_bit;
      s[ST_NULL]               = null_bit;
      s[ST_RW_HI:ST_RW_LO]     = rw;
      s[ST_MODE_HI:ST_MODE_LO] = mode_raw;
      s[ST_BIT0]               = bit0;
      return s;
   endfunction

endpackage

// File: rtl/kf_pit_counter_wide_if.sv
// Byte-serial internal bus between the PIT decoder and one counter channel.
interface kf_pit_counter_wide_if;
   logic [7:0] internal_data_bus;
   logic       write_control;
   logic       write_counter;
   logic       read_counter;
   logic [7:0] read_counter_data;

   modport master (
      output internal_data_bus,
      output write_control,
      output write_counter,
      output read_counter,
      input  read_counter_data
   );

   modport slave (
      input  internal_data_bus,
      input  write_control,
      input  write_counter,
      input  read_counter,
      output read_counter_data
   );
endinterface

// File: rtl/kf_pit_edge_sync.sv
// Samples the external count clock and gate into the system clock domain and
// produces single-cycle pulses for a count-clock fall and a gate rise.
module kf_pit_edge_sync (
   input  logic clock,
   input  logic reset_n,
   input  logic counter_clock,
   input  logic counter_gate,
   output logic count_edge,
   output logic gate_rise
);

   logic [1:0] clk_q;
   logic [1:0] gate_q;

   // Two-deep sample history of both external pins.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         clk_q  <= 2'b00;
         gate_q <= 2'b00;
      end else begin
         clk_q  <= {clk_q[0], counter_clock};
         gate_q <= {gate_q[0], counter_gate};
      end
   end

   assign count_edge = clk_q[1] & ~clk_q[0];
   assign gate_rise  = gate_q[0] & ~gate_q[1];

endmodule

// File: rtl/kf_pit_counter_wide.sv
// One programmable down-counter channel of the PIT with configurable width.
// Byte-serial preset/readback, count and status latches, modes 0, 2 and 3.
module kf_pit_counter_wide
   import kf_pit_pkg::*;
#(
   parameter int unsigned COUNT_BYTES = 2,
   parameter bit          RESET_OUT   = 1'b0
) (
   input  logic                  clock,
   input  logic                  reset_n,
   kf_pit_counter_wide_if.slave  bus,
   input  logic                  counter_clock,
   input  logic                  counter_gate,
   output logic                  counter_out
);

   localparam int unsigned W = 8 * COUNT_BYTES;
   localparam logic [1:0]  LAST_PTR   = 2'(COUNT_BYTES - 1);
   localparam logic [W-1:0] PRESET_ONE = {{(W-1){1'b0}}, 1'b1};
   localparam logic [W:0]  ONE   = {{W{1'b0}}, 1'b1};
   localparam logic [W:0]  TWO   = {{(W-1){1'b0}}, 2'b10};
   localparam logic [W:0]  THREE = {{(W-1){1'b0}}, 2'b11};

   logic       count_edge;
   logic       gate_rise;

   logic [2:0] mode_raw_q;
   logic       bit0_q;
   rw_e        rw_q;
   mode_e      mode;

   // Count carries an extra bit so a preset of 0 can be held as 2^W.
   logic [W:0]   count_q;
   logic [W-1:0] preset_q;
   logic [W-1:0] cl_data_q;
   logic [7:0]   st_data_q;
   logic         cl_valid_q;
   logic         st_valid_q;
   logic [1:0]   wr_ptr_q;
   logic [1:0]   rd_ptr_q;
   logic         null_q;
   logic         load_pend_q;
   logic         run_q;
   logic         out_q;
   logic         reload_req_q;

   logic [W:0]   reload_n;
   logic [W:0]   cnt_dec1;
   logic [W:0]   m3_dec;
   logic [31:0]  cnt_pad;
   logic [31:0]  cl_pad;
   logic [7:0]   read_byte;

   kf_pit_edge_sync u_edge_sync (
      .clock         (clock),
      .reset_n       (reset_n),
      .counter_clock (counter_clock),
      .counter_gate  (counter_gate),
      .count_edge    (count_edge),
      .gate_rise     (gate_rise)
   );

   assign mode     = decode_mode(mode_raw_q);
   assign cnt_dec1 = count_q - ONE;
   assign cnt_pad  = 32'(count_q[W-1:0]);
   assign cl_pad   = 32'(cl_data_q);

   // Reload value: preset 0 means 2^W; periodic modes cannot run with a period of 1.
   always_comb begin
      reload_n = {1'b0, preset_q};
      if (preset_q == '0) begin
         reload_n = {1'b1, {W{1'b0}}};
      end else if (preset_q == PRESET_ONE && mode != MODE0) begin
         reload_n = TWO;
      end
   end

   // Square-wave step: an odd count only occurs on the first edge of a half period.
   always_comb begin
      m3_dec = TWO;
      if (count_q[0]) begin
         m3_dec = out_q ? ONE : THREE;
      end
   end

   // Read byte source: status latch, then count latch, then the live count.
   always_comb begin
      read_byte = cnt_pad[{rd_ptr_q, 3'b000} +: 8];
      if (st_valid_q) begin
         read_byte = st_data_q;
      end else if (cl_valid_q) begin
         read_byte = cl_pad[{rd_ptr_q, 3'b000} +: 8];
      end
   end

   assign bus.read_counter_data = read_byte;
   assign counter_out           = out_q;

   // Channel state: control decode, preset writes, readback pointers and counting.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mode_raw_q   <= 3'b000;
         bit0_q       <= 1'b0;
         rw_q         <= RW_FULL;
         count_q      <= '0;
         preset_q     <= '0;
         cl_data_q    <= '0;
         st_data_q    <= 8'h00;
         cl_valid_q   <= 1'b0;
         st_valid_q   <= 1'b0;
         wr_ptr_q     <= 2'd0;
         rd_ptr_q     <= 2'd0;
         null_q       <= 1'b0;
         load_pend_q  <= 1'b0;
         run_q        <= 1'b0;
         out_q        <= RESET_OUT;
         reload_req_q <= 1'b0;
      end else if (bus.write_control) begin
         // A control word pre-empts bus writes, reads and any count edge this cycle.
         case (rw_e'(bus.internal_data_bus[5:4]))
            RW_LATCH: begin
               if (!cl_valid_q) begin
                  cl_valid_q <= 1'b1;
                  cl_data_q  <= count_q[W-1:0];
               end
            end
            RW_STATUS: begin
               if (!st_valid_q) begin
                  st_valid_q <= 1'b1;
                  st_data_q  <= status_byte(out_q, null_q, rw_q, mode_raw_q, bit0_q);
               end
            end
            default: begin
               mode_raw_q   <= bus.internal_data_bus[3:1];
               bit0_q       <= bus.internal_data_bus[0];
               rw_q         <= rw_e'(bus.internal_data_bus[5:4]);
               cl_valid_q   <= 1'b0;
               st_valid_q   <= 1'b0;
               wr_ptr_q     <= 2'd0;
               rd_ptr_q     <= 2'd0;
               run_q        <= 1'b0;
               load_pend_q  <= 1'b0;
               reload_req_q <= 1'b0;
               null_q       <= 1'b1;
               out_q        <= (decode_mode(bus.internal_data_bus[3:1]) != MODE0);
            end
         endcase
      end else begin
         if (count_edge && mode != MODE_RSVD) begin
            if (load_pend_q && (!run_q || mode == MODE0)) begin
               count_q      <= reload_n;
               load_pend_q  <= 1'b0;
               null_q       <= 1'b0;
               run_q        <= 1'b1;
               reload_req_q <= 1'b0;
               if (mode != MODE0) begin
                  out_q <= 1'b1;
               end
            end else if (run_q && counter_gate) begin
               if (mode == MODE0) begin
                  count_q <= (count_q == '0) ? {1'b0, {W{1'b1}}} : cnt_dec1;
                  if (count_q == ONE) begin
                     out_q <= 1'b1;
                  end
               end else if (reload_req_q) begin
                  count_q      <= reload_n;
                  load_pend_q  <= 1'b0;
                  null_q       <= 1'b0;
                  reload_req_q <= 1'b0;
                  out_q        <= 1'b1;
               end else if (mode == MODE2) begin
                  if (count_q == TWO) begin
                     count_q <= ONE;
                     out_q   <= 1'b0;
                  end else if (count_q <= ONE) begin
                     count_q     <= reload_n;
                     load_pend_q <= 1'b0;
                     null_q      <= 1'b0;
                     out_q       <= 1'b1;
                  end else begin
                     count_q <= cnt_dec1;
                  end
               end else begin
                  if (count_q <= m3_dec) begin
                     count_q     <= reload_n;
                     load_pend_q <= 1'b0;
                     null_q      <= 1'b0;
                     out_q       <= ~out_q;
                  end else begin
                     count_q <= count_q - m3_dec;
                  end
               end
            end
         end

         if (bus.write_counter) begin
            if (rw_q == RW_LSB) begin
               preset_q <= W'(bus.internal_data_bus);
            end else begin
               for (int b = 0; b < COUNT_BYTES; b++) begin
                  if (wr_ptr_q == 2'(b)) begin
                     preset_q[8*b +: 8] <= bus.internal_data_bus;
                  end
               end
            end
            // Mode 0 stops and drops out as soon as a new preset starts.
            if (mode == MODE0 && wr_ptr_q == 2'd0) begin
               run_q <= 1'b0;
               out_q <= 1'b0;
            end
            if (rw_q == RW_LSB || wr_ptr_q == LAST_PTR) begin
               wr_ptr_q    <= 2'd0;
               null_q      <= 1'b1;
               load_pend_q <= 1'b1;
            end else begin
               wr_ptr_q <= wr_ptr_q + 2'd1;
            end
         end

         if (bus.read_counter) begin
            if (st_valid_q) begin
               st_valid_q <= 1'b0;
            end else if (rw_q == RW_LSB || rd_ptr_q == LAST_PTR) begin
               rd_ptr_q   <= 2'd0;
               cl_valid_q <= 1'b0;
            end else begin
               rd_ptr_q <= rd_ptr_q + 2'd1;
            end
         end

         if (mode == MODE2 || mode == MODE3) begin
            if (!counter_gate) begin
               out_q <= 1'b1;
            end
            if (gate_rise && run_q) begin
               reload_req_q <= 1'b1;
            end
         end
      end
   end

endmodule
